uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 2, is the number of idle cycles with tx_start low between frames; the legal range SHALL be 1..15.
REQ-002 Parameter START_TIMEOUT, default 4, is the maximum number of cycles to wait for tx_busy to rise after tx_start asserts; the legal range SHALL be 2..15.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  4  per-requester byte-pending flag; bit i belongs to requester i.
REQ-006 req_data  input  32  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 req_ready  output  4  one-cycle, one-hot pulse when requester i's byte is captured.
REQ-008 tx_done  output  4  one-cycle, one-hot pulse when requester i's frame completes.
REQ-009 tx_start  output  1  frame request to the transmitter, held high for the whole frame.
REQ-010 tx_data  output  8  byte presented to the transmitter's data_in.
REQ-011 tx_busy  input  1  transmitter busy flag.
REQ-012 timeout_err  output  1  one-cycle pulse when tx_busy fails to rise within START_TIMEOUT.
REQ-013 owner  output  2  index of the requester currently granted; valid only outside IDLE.

Function
REQ-014 The block SHALL implement four states: IDLE, LAUNCH, SEND, GAP.
REQ-015 IDLE: if any req_valid bit is set, the block SHALL grant one requester by round-robin, starting the search at (last_grant+1) mod 4.
REQ-016 On the grant cycle, the block SHALL capture req_data of the winner into tx_data, register owner, pulse req_ready[owner], and enter LAUNCH.
REQ-017 tx_data SHALL be stable from capture until the block returns to IDLE; later changes on req_data SHALL be ignored.
REQ-018 LAUNCH: tx_start SHALL be 1; when tx_busy=1 the block SHALL enter SEND.
REQ-019 LAUNCH: if tx_busy has not risen after START_TIMEOUT cycles, the block SHALL pulse timeout_err, drop tx_start, and enter GAP; no tx_done SHALL be issued.
REQ-020 SEND: tx_start SHALL stay 1; on the first cycle with tx_busy=0, the block SHALL drop tx_start, pulse tx_done[owner], and enter GAP.
REQ-021 GAP: tx_start SHALL be 0 for exactly GAP_CYCLES cycles, then the block SHALL enter IDLE; requests SHALL NOT be granted during GAP.
REQ-022 Minimum grant-to-grant spacing SHALL be 1 (grant) + LAUNCH cycles + SEND cycles + GAP_CYCLES; no back-to-back frames without a gap.
REQ-023 last_grant SHALL update on every grant, including grants that end in a timeout.
REQ-024 A req_valid bit that drops before being granted SHALL be silently dropped; no req_ready pulse SHALL be issued for it.
REQ-025 At most one bit of req_ready, tx_done or timeout_err SHALL be high in any cycle.
REQ-026 The LAUNCH timeout counter and the GAP counter SHALL each be 4 bits wide and SHALL clear on every state entry.

Reset
REQ-027 Asserting rst SHALL asynchronously force: state=IDLE, tx_start=0, tx_data=0, req_ready=0, tx_done=0, timeout_err=0, owner=0, last_grant=3, counters=0.
REQ-028 Reset mid-frame SHALL drop tx_start immediately; no tx_done pulse SHALL be issued for the aborted frame.
REQ-029 After rst deasserts, the first grant SHALL search from requester 0.

Structure
REQ-030 State encoding, the requester count (4), and default GAP/timeout constants SHALL live in the shared package uart_pkg.
REQ-031 Round-robin selection SHALL be a separate combinational sub-module, rr_arbiter_4, with inputs req[3:0] and last[1:0] and outputs gnt_idx[1:0] and any_req.

Verification
REQ-032 Single request: req_valid=4'b0001, req_data[7:0]=8'hA5, transmitter model busy for 11 cycles -> req_ready[0] pulses once, tx_data=8'hA5, tx_start high throughout busy, tx_done[0] pulses once, then exactly 2 low cycles.
REQ-033 All four requesters valid continuously -> grant order 0,1,2,3,0; no requester is skipped or granted twice in a row.
REQ-034 Busy never rises -> timeout_err pulses 4 cycles after LAUNCH entry, tx_start drops, no tx_done, and the next requester is granted after GAP.
REQ-035 rst asserted during SEND with owner=2 -> tx_start=0 within the same cycle; no tx_done; first post-reset grant goes to requester 0.
REQ-036 req_data[15:8] changes from 8'h3C to 8'hFF during SEND of requester 1 -> tx_data stays 8'h3C.
REQ-037 req_valid[3] pulses for 1 cycle while the block is in GAP -> no req_ready[3] and no frame for requester 3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: requester count,
// default timing constants and the scheduler state encoding.
package uart_pkg;

  localparam int NUM_REQ               = 4;
  localparam int DEF_GAP_CYCLES        = 2;
  localparam int DEF_START_TIMEOUT     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_SEND   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin selector. The search starts one past the last
// granted requester, so the most recent winner has the lowest priority.
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any_req
);

  // Walk candidates from farthest to nearest so the nearest pending one wins.
  always_comb begin
    gnt_idx = last;
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) gnt_idx = last + 2'(k);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among four byte requesters. A frame is
// IDLE(grant) -> LAUNCH (wait for tx_busy) -> SEND (wait for tx_busy low)
// -> GAP (enforced quiet time) -> IDLE.
//
// Handshakes: req_valid[i] is a level that the scheduler samples only in
// IDLE; the byte is taken on the sampling edge and req_ready[i] pulses for
// one cycle after it. tx_start is a level held for the whole frame; the
// transmitter answers by raising tx_busy and ends the frame by dropping it.
// Legal ranges: GAP_CYCLES 1..15, START_TIMEOUT 2..15.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   tx_done,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 timeout_err,
  output logic [1:0]           owner,
  output state_e               dbg_state
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] TO_LAST  = 4'(START_TIMEOUT - 1);

  state_e       state_q;
  logic [3:0]   to_cnt_q;
  logic [3:0]   gap_cnt_q;
  logic [1:0]   last_q;
  logic [1:0]   owner_q;
  logic [7:0]   data_q;
  logic         start_q;
  logic [3:0]   ready_q;
  logic [3:0]   done_q;
  logic         to_q;

  logic [1:0]   gnt_idx_d;
  logic         any_req_d;

  rr_arbiter_4 u_arb (
    .req     (req_valid),
    .last    (last_q),
    .gnt_idx (gnt_idx_d),
    .any_req (any_req_d)
  );

  // Frame sequencer; all outputs are registered and pulses last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      to_cnt_q  <= 4'd0;
      gap_cnt_q <= 4'd0;
      last_q    <= 2'd3;
      owner_q   <= 2'd0;
      data_q    <= 8'd0;
      start_q   <= 1'b0;
      ready_q   <= 4'd0;
      done_q    <= 4'd0;
      to_q      <= 1'b0;
    end else begin
      ready_q <= 4'd0;
      done_q  <= 4'd0;
      to_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            owner_q   <= gnt_idx_d;
            last_q    <= gnt_idx_d;
            data_q    <= req_data[{gnt_idx_d, 3'b000} +: 8];
            ready_q   <= 4'b0001 << gnt_idx_d;
            start_q   <= 1'b1;
            to_cnt_q  <= 4'd0;
            gap_cnt_q <= 4'd0;
            state_q   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (tx_busy) begin
            to_cnt_q  <= 4'd0;
            gap_cnt_q <= 4'd0;
            state_q   <= ST_SEND;
          end else if (to_cnt_q == TO_LAST) begin
            to_q      <= 1'b1;
            start_q   <= 1'b0;
            to_cnt_q  <= 4'd0;
            gap_cnt_q <= 4'd0;
            state_q   <= ST_GAP;
          end else begin
            to_cnt_q <= to_cnt_q + 4'd1;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            start_q   <= 1'b0;
            done_q    <= 4'b0001 << owner_q;
            to_cnt_q  <= 4'd0;
            gap_cnt_q <= 4'd0;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            to_cnt_q  <= 4'd0;
            gap_cnt_q <= 4'd0;
            state_q   <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign tx_done     = done_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign timeout_err = to_q;
  assign owner       = owner_q;
  assign dbg_state   = state_q;

endmodule
